// File: rtl/block_mover.sv
// Falling-piece controller: spawns a four-square shape, applies gravity and
// left/right moves against the occupancy array, and flags landing or top-out.
module block_mover #(
    parameter int unsigned SPAWN_X = 3,
    parameter int unsigned SPAWN_Y = 10
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         gen_flag,
    input  logic         tick,
    input  logic         btn_left,
    input  logic         btn_right,
    input  logic         shape_sel_en,
    input  logic [1:0]   shape_sel,
    input  logic [119:0] arr,
    output logic [31:0]  block,
    output logic         bottom_flag,
    output logic         top_flag,
    output logic         active,
    output logic [1:0]   piece_id
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPAWN,
        S_FALL,
        S_LANDED,
        S_DEAD
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_lfsr;
    logic [3:0]  r_ax, r_ay, w_ax, w_ay;
    logic [1:0]  r_shape, w_shape;
    logic [31:0] r_block, w_block;
    logic        r_bottom, r_top, r_active;
    logic        w_top;
    logic [1:0]  w_spawn_shape;
    logic [2:0]  w_width;
    logic        w_spawn_hit, w_down_hit, w_left_hit, w_right_hit;

    // {dx,dy} pairs for square1..square4, two bits each
    function automatic logic [15:0] f_offsets(input logic [1:0] shp);
        case (shp)
            2'd0:    return 16'b00_00_01_00_00_01_01_01;
            2'd1:    return 16'b00_00_01_00_10_00_11_00;
            2'd2:    return 16'b00_01_01_01_10_01_01_00;
            default: return 16'b00_00_01_00_01_01_10_01;
        endcase
    endfunction

    function automatic logic [2:0] f_width(input logic [1:0] shp);
        case (shp)
            2'd0:    return 3'd2;
            2'd1:    return 3'd4;
            default: return 3'd3;
        endcase
    endfunction

    function automatic logic [31:0] f_pack(input logic [1:0] shp,
                                           input logic [3:0] ax,
                                           input logic [3:0] ay);
        logic [31:0] blk;
        logic [15:0] o;
        blk = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            o   = f_offsets(shp) << (4 * i);
            blk = {blk[23:0], ax + 4'(o[15:14]), ay + 4'(o[13:12])};
        end
        return blk;
    endfunction

    // Off-grid cells count as occupied so the moved piece can never wrap.
    function automatic logic f_blocked(input logic [119:0] a,
                                       input logic [31:0]  blk,
                                       input int           ddx,
                                       input int           ddy);
        logic        hit;
        logic [31:0] t;
        int          x, y;
        hit = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            t = blk << (8 * i);
            x = int'({28'd0, t[31:28]}) + ddx;
            y = int'({28'd0, t[27:24]}) + ddy;
            if (x < 0 || x > 9 || y < 0 || y > 11)
                hit = 1'b1;
            else
                hit = hit | a[7'(x * 12 + y)];
        end
        return hit;
    endfunction

    assign w_width       = f_width(r_shape);
    assign w_spawn_shape = shape_sel_en ? shape_sel : r_lfsr[1:0];
    assign w_spawn_hit   = f_blocked(arr, r_block, 0, 0);
    assign w_down_hit    = (r_ay == 4'd0) || f_blocked(arr, r_block, 0, -1);
    assign w_left_hit    = (r_ax == 4'd0) || f_blocked(arr, r_block, -1, 0);
    assign w_right_hit   = (({1'b0, r_ax} + {2'b0, w_width}) > 5'd9)
                           || f_blocked(arr, r_block, 1, 0);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state  <= S_IDLE;
            r_lfsr   <= 8'hA5;
            r_ax     <= '0;
            r_ay     <= '0;
            r_shape  <= '0;
            r_block  <= '0;
            r_bottom <= 1'b0;
            r_top    <= 1'b0;
            r_active <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_lfsr   <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
            r_ax     <= w_ax;
            r_ay     <= w_ay;
            r_shape  <= w_shape;
            r_block  <= w_block;
            r_bottom <= (w_state_nxt == S_LANDED);
            r_top    <= w_top;
            r_active <= (w_state_nxt == S_FALL);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DEAD: if (gen_flag) w_state_nxt = S_SPAWN;
            S_SPAWN:        w_state_nxt = w_spawn_hit ? S_DEAD : S_FALL;
            S_FALL:         if (tick && w_down_hit) w_state_nxt = S_LANDED;
            S_LANDED:       w_state_nxt = S_IDLE;
            default:        w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_ax    = r_ax;
        w_ay    = r_ay;
        w_shape = r_shape;
        w_block = r_block;
        w_top   = r_top;
        case (r_state)
            S_IDLE, S_DEAD: begin
                if (gen_flag) begin
                    w_shape = w_spawn_shape;
                    w_ax    = 4'(SPAWN_X);
                    w_ay    = 4'(SPAWN_Y);
                    w_top   = 1'b0;
                    w_block = f_pack(w_spawn_shape, 4'(SPAWN_X), 4'(SPAWN_Y));
                end
            end
            S_SPAWN: begin
                if (w_spawn_hit) w_top = 1'b1;
            end
            S_FALL: begin
                // Gravity wins over buttons; opposing buttons cancel.
                if (tick) begin
                    if (!w_down_hit) begin
                        w_ay    = r_ay - 4'd1;
                        w_block = f_pack(r_shape, r_ax, r_ay - 4'd1);
                    end
                end else if (btn_left && !btn_right && !w_left_hit) begin
                    w_ax    = r_ax - 4'd1;
                    w_block = f_pack(r_shape, r_ax - 4'd1, r_ay);
                end else if (btn_right && !btn_left && !w_right_hit) begin
                    w_ax    = r_ax + 4'd1;
                    w_block = f_pack(r_shape, r_ax + 4'd1, r_ay);
                end
            end
            default: ;
        endcase
    end

    assign block       = r_block;
    assign bottom_flag = r_bottom;
    assign top_flag    = r_top;
    assign active      = r_active;
    assign piece_id    = r_shape;

endmodule

// File: tb/tb_block_mover.sv
// Directed bench for block_mover: spawn, gravity, moves, collisions,
// top-out and asynchronous reset behaviour.
module tb_block_mover;

    logic         Clk;
    logic         Reset_n;
    logic         gen_flag;
    logic         tick;
    logic         btn_left;
    logic         btn_right;
    logic         shape_sel_en;
    logic [1:0]   shape_sel;
    logic [119:0] arr;
    logic [31:0]  block;
    logic         bottom_flag;
    logic         top_flag;
    logic         active;
    logic [1:0]   piece_id;

    int n_checks = 0;
    int n_errors = 0;

    block_mover #(.SPAWN_X(3), .SPAWN_Y(10)) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .gen_flag     (gen_flag),
        .tick         (tick),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .shape_sel_en (shape_sel_en),
        .shape_sel    (shape_sel),
        .arr          (arr),
        .block        (block),
        .bottom_flag  (bottom_flag),
        .top_flag     (top_flag),
        .active       (active),
        .piece_id     (piece_id)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        Reset_n      = 1'b1;
        gen_flag     = 1'b0;
        tick         = 1'b0;
        btn_left     = 1'b0;
        btn_right    = 1'b0;
        shape_sel_en = 1'b0;
        shape_sel    = 2'd0;
        arr          = '0;

        // Asynchronous reset between clock edges
        #3 Reset_n = 1'b0;
        #1;
        chk("rst_block",  block, 32'h0);
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_top",    32'(top_flag), 32'd0);
        chk("rst_bottom", 32'(bottom_flag), 32'd0);
        chk("rst_piece",  32'(piece_id), 32'd0);
        chk("rst_lfsr",   32'(dut.r_lfsr), 32'hA5);

        // First edge after release samples lfsr=A5 -> shape 1 (I)
        gen_flag = 1'b1;
        @(posedge Clk);
        @(posedge Clk);
        #7 Reset_n = 1'b1;
        step();
        gen_flag = 1'b0;
        chk("lfsr_I_block", block, 32'h3A4A5A6A);
        chk("lfsr_I_piece", 32'(piece_id), 32'd1);
        step();
        chk("I_active", 32'(active), 32'd1);
        chk("I_top",    32'(top_flag), 32'd0);

        for (int i = 0; i < 5; i++) begin
            btn_right = 1'b1; step();
            btn_right = 1'b0; step();
        end
        chk("I_right5", block, 32'h6A7A8A9A);
        btn_right = 1'b1; step();
        btn_right = 1'b0; step();
        chk("I_right_wall", block, 32'h6A7A8A9A);

        tick = 1'b1; btn_left = 1'b1; step();
        tick = 1'b0; btn_left = 1'b0;
        chk("tick_beats_left", block, 32'h69798999);
        btn_left = 1'b1; btn_right = 1'b1; step();
        btn_left = 1'b0; btn_right = 1'b0;
        chk("both_buttons", block, 32'h69798999);
        btn_left = 1'b1; step();
        btn_left = 1'b0;
        chk("I_left", block, 32'h59697989);

        // Mid-fall reset: outputs clear without a clock edge
        #2 Reset_n = 1'b0;
        #1;
        chk("midrst_block",  block, 32'h0);
        chk("midrst_active", 32'(active), 32'd0);
        chk("midrst_lfsr",   32'(dut.r_lfsr), 32'hA5);
        step();
        step();
        chk("midrst_bottom", 32'(bottom_flag), 32'd0);
        chk("midrst_top",    32'(top_flag), 32'd0);
        #3 Reset_n = 1'b1;
        step();
        chk("post_rst_idle", 32'(active), 32'd0);

        // O piece: spawn, gen ignored in FALL, full fall and landing
        shape_sel_en = 1'b1; shape_sel = 2'd0;
        gen_flag = 1'b1; step();
        gen_flag = 1'b0;
        chk("O_spawn_block", block, 32'h3A4A3B4B);
        step();
        chk("O_active", 32'(active), 32'd1);
        chk("O_top",    32'(top_flag), 32'd0);
        shape_sel = 2'd2; gen_flag = 1'b1; step();
        gen_flag = 1'b0; shape_sel = 2'd0;
        chk("gen_in_fall_block", block, 32'h3A4A3B4B);
        chk("gen_in_fall_piece", 32'(piece_id), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick = 1'b1; step();
            tick = 1'b0; step();
        end
        chk("O_floor_block", block, 32'h30403141);
        chk("O_floor_bottom", 32'(bottom_flag), 32'd0);
        tick = 1'b1; step();
        tick = 1'b0;
        chk("land_bottom", 32'(bottom_flag), 32'd1);
        chk("land_block",  block, 32'h30403141);
        chk("land_active", 32'(active), 32'd0);
        step();
        chk("land_pulse_end", 32'(bottom_flag), 32'd0);
        chk("land_block_hold", block, 32'h30403141);

        // Collisions against arr: left neighbour and cell below
        arr = '0; arr[2*12+10] = 1'b1;
        gen_flag = 1'b1; step();
        gen_flag = 1'b0; step();
        chk("coll_active", 32'(active), 32'd1);
        btn_left = 1'b1; step();
        btn_left = 1'b0;
        chk("left_blocked", block, 32'h3A4A3B4B);
        arr = '0; arr[3*12+9] = 1'b1;
        tick = 1'b1; step();
        tick = 1'b0;
        chk("stack_bottom", 32'(bottom_flag), 32'd1);
        chk("stack_block",  block, 32'h3A4A3B4B);
        step();
        chk("stack_pulse_end", 32'(bottom_flag), 32'd0);

        // Top-out at spawn
        arr = '0; arr[3*12+10] = 1'b1;
        gen_flag = 1'b1; step();
        gen_flag = 1'b0;
        chk("dead_top_c1", 32'(top_flag), 32'd0);
        step();
        chk("dead_top_c2",  32'(top_flag), 32'd1);
        chk("dead_bottom",  32'(bottom_flag), 32'd0);
        chk("dead_active",  32'(active), 32'd0);
        tick = 1'b1; btn_right = 1'b1; step();
        tick = 1'b0; btn_right = 1'b0; step();
        chk("dead_top_hold",   32'(top_flag), 32'd1);
        chk("dead_block_hold", block, 32'h3A4A3B4B);

        // Respawn from DEAD with T
        arr = '0; shape_sel = 2'd2;
        gen_flag = 1'b1; step();
        gen_flag = 1'b0;
        chk("T_top_clear", 32'(top_flag), 32'd0);
        chk("T_block",     block, 32'h3B4B5B4A);
        chk("T_piece",     32'(piece_id), 32'd2);
        step();
        chk("T_active", 32'(active), 32'd1);

        // S shape after a reset pulse
        #2 Reset_n = 1'b0;
        #3 Reset_n = 1'b1;
        shape_sel = 2'd3;
        gen_flag = 1'b1; step();
        gen_flag = 1'b0;
        chk("S_block", block, 32'h3A4A4B5B);
        chk("S_piece", 32'(piece_id), 32'd3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/block_mover.md
BLOCK_MOVER -- requirements
Module: block_mover

Interface
REQ-001 Parameters: SPAWN_X, default 3, anchor column at spawn; SPAWN_Y, default 10, anchor row at spawn.
REQ-002 Clk  input  1  rising-edge system clock.
REQ-003 Reset_n  input  1  the reset is asynchronous and active-low.
REQ-004 gen_flag  input  1  spawn request from game array, sampled high in IDLE or DEAD.
REQ-005 tick  input  1  gravity strobe, one-cycle pulse.
REQ-006 btn_left, btn_right  input  1 each  debounced one-cycle move pulses.
REQ-007 shape_sel_en, shape_sel  input  1, 2  test override: when shape_sel_en=1 at spawn, use shape_sel instead of LFSR.
REQ-008 arr  input  120  occupancy, bit x*12+y, column x 0..9, row y 0..11, row 0 = bottom.
REQ-009 block  output  32  four squares {x[3:0],y[3:0]}: square1 [31:24], square2 [23:16], square3 [15:8], square4 [7:0].
REQ-010 bottom_flag  output  1  piece landed; one-cycle pulse.
REQ-011 top_flag  output  1  spawn collided; level.
REQ-012 active  output  1  piece is live (state FALL).
REQ-013 piece_id  output  2  current shape.

Function
REQ-014 States IDLE, SPAWN, FALL, LANDED, DEAD; all outputs registered.
REQ-015 Shapes, as (dx,dy) offsets from the lower-left anchor (ax,ay), listed in square1..4 order:
- 0 O: (0,0)(1,0)(0,1)(1,1), width 2.
- 1 I: (0,0)(1,0)(2,0)(3,0), width 4.
- 2 T: (0,1)(1,1)(2,1)(1,0), width 3.
- 3 S: (0,0)(1,0)(1,1)(2,1), width 3.
REQ-016 LFSR: 8-bit, advances every clock, taps x^8+x^6+x^5+x^4+1; shape = lfsr[1:0] at the spawn sample.
REQ-017 IDLE or DEAD with gen_flag=1: latch the shape, set ax=SPAWN_X and ay=SPAWN_Y, clear top_flag, go to SPAWN; block is updated on the same edge.
REQ-018 SPAWN, one cycle:
- If any square is occupied in arr: top_flag=1, go to DEAD.
- Otherwise go to FALL.
REQ-019 FALL with tick=1: attempt a move down.
- If ay==0 or any square at (x,y-1) is occupied: bottom_flag=1 for the next cycle, go to LANDED, block unchanged.
- Otherwise decrement ay.
REQ-020 FALL with tick=0 and exactly one of btn_left/btn_right:
- Left: decrement ax if ax>0 and all cells at (x-1,y) are free.
- Right: increment ax if ax+width<=9 and all cells at (x+1,y) are free.
- Otherwise no change.
REQ-021 Simultaneous events:
- tick has priority; buttons asserted in the same cycle as tick are discarded.
- btn_left and btn_right together are ignored.
REQ-022 LANDED, one cycle, bottom_flag=1 and block stable: go to IDLE; bottom_flag returns to 0.
REQ-023 DEAD: top_flag held at 1 and block held; tick and buttons ignored; exit only via gen_flag or reset.
REQ-024 gen_flag is ignored in SPAWN, FALL, and LANDED.
REQ-025 Collision checks use arr as sampled in the same cycle as the move decision.
REQ-026 Coordinates are 4-bit unsigned; legal movement never produces x>9 or y>11, and no wrap-around.

Reset
REQ-027 With Reset_n=0, immediately and independent of Clk:
- state=IDLE, block=32'h0, bottom_flag=0, top_flag=0, active=0, piece_id=0.
- lfsr=8'hA5, ax=0, ay=0.
REQ-028 Reset asserted mid-fall abandons the piece; no flag pulse is produced.

Verification
REQ-029 Empty arr, shape_sel_en=1, shape_sel=0, gen_flag pulse -> block=32'h3A4A3B4B; after SPAWN, active=1, top_flag=0.
REQ-030 Same piece, 10 ticks -> block=32'h30403141; 11th tick -> bottom_flag high exactly 1 cycle, block unchanged, then IDLE.
REQ-031 I piece, 5 btn_right pulses with no tick -> ax=6, block=32'h6A7A8A9A; later presses give no change.
REQ-032 arr bit (3*12+10) set, spawn shape 0 -> top_flag=1 two cycles after gen_flag, bottom_flag=0; top_flag stays 1 until the next gen_flag.
REQ-033 FALL, tick and btn_left in the same cycle -> only ay decrements, ax unchanged; btn_left and btn_right together -> no change.
REQ-034 Reset_n low during FALL -> block=0 and active=0 without a clock edge; after release, state=IDLE and lfsr=8'hA5.
